ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single 512x8 dual-address RAM between two requesters: the serial monitor (port m_) and the CPU (port c_).
- Replaces the static monitor_control muxing with a request/acknowledge protocol, so the monitor can inspect or patch memory while the CPU runs.
- Sits between both requesters and the RAM's din/write_en/waddr/raddr/dout pins.
- All RAM-side outputs are registered.

Parameters:
- ADDR_W, 9, RAM address width in bits.
- DATA_W, 8, RAM data width in bits.

Ports:
- clk  input  1  system clock (iCE_CLK at top level)
- rst_n  input  1  reset, synchronous, active-low
- m_req  input  1  monitor access request; held until m_ack
- m_we  input  1  monitor request is a write (1) or read (0)
- m_addr  input  ADDR_W  monitor address
- m_wdata  input  DATA_W  monitor write data
- m_lock  input  1  monitor exclusive ownership; CPU is never granted while high
- m_ack  output  1  one-cycle pulse: monitor request issued to RAM
- m_rvalid  output  1  one-cycle pulse: m_rdata updated
- m_rdata  output  DATA_W  last monitor read data
- c_req, c_we, c_addr, c_wdata  input  1/1/ADDR_W/DATA_W  CPU equivalents of the m_ signals
- c_ack, c_rvalid, c_rdata  output  1/1/DATA_W  CPU equivalents of the m_ signals
- r_waddr  output  ADDR_W  RAM write address
- r_raddr  output  ADDR_W  RAM read address
- r_din  output  DATA_W  RAM write data
- r_write_en  output  1  RAM write strobe
- r_dout  input  DATA_W  RAM read data; registered in the RAM, valid one cycle after raddr

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE; last_winner=C.
  - All outputs 0: acks, rvalids, rdata, r_waddr, r_raddr, r_din, r_write_en.
  - Any in-flight transaction is abandoned with no ack or rvalid.
- States: IDLE, WRITE, READ, RWAIT.
- IDLE: evaluate eligible requests (c_req is eligible only if m_lock=0).
  - No eligible request: stay in IDLE.
  - Winner selection: monitor wins whenever both are eligible (fixed priority; see Optional Feature).
  - Winner with we=1: load r_waddr/r_din from the winner; go to WRITE.
  - Winner with we=0: load r_raddr; go to READ.
  - Record winner in the owner register.
- WRITE (one cycle):
  - r_write_en=1; owner's ack=1.
  - Next state: IDLE; r_write_en returns to 0.
- READ (one cycle):
  - r_raddr is stable on the RAM; owner's ack=1.
  - Next state: RWAIT.
- RWAIT (one cycle):
  - Owner's rdata <= r_dout; owner's rvalid pulses in the following cycle.
  - Next state: IDLE.
- Latency, request seen in IDLE at cycle N:
  - Write: ack and r_write_en at N+1; next grant possible from N+2.
  - Read: ack at N+1; rvalid with data at N+3; next grant possible from N+3.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack; drop or replace them in the cycle after ack.
  - Commands are captured at grant, so changes after grant do not affect the transaction.
- Lock:
  - m_lock rising while a CPU transaction is in WRITE/READ/RWAIT: that transaction completes normally (ack, rvalid).
  - Blocking applies from the next IDLE.
- Idle-time signal values:
  - r_waddr/r_raddr/r_din hold their last values.
  - r_write_en is high only in WRITE.
- Data retention: each port's rdata holds until that port's next read completes; the other port's reads never modify it.
- Ack/rvalid exclusivity: at most one ack and at most one rvalid are high per cycle.
- Address width: no width conversion; addresses pass through unmodified (no wrap logic).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both ports are eligible in IDLE, the port that did not win the previous grant wins, then last_winner updates. A single eligible port always wins immediately.
- Undefined: fixed priority, monitor always wins; last_winner is still maintained but unused.

Test Plan:
- Reset, then monitor write addr 0x005 data 0xA5:
  - m_ack and r_write_en=1 with r_waddr=0x005, r_din=0xA5 exactly one cycle after req.
  - Monitor read of 0x005: m_rvalid at req+3 with m_rdata=0xA5.
- m_req and c_req asserted in the same cycle (writes to 0x010 and 0x011), macro undefined:
  - Monitor acked first, CPU acked 2 cycles later.
  - With ARB_ROUND_ROBIN_EN and CPU winning the previous grant: monitor first. Repeat the pair: CPU first.
- m_lock=1, c_req held for 20 cycles: no c_ack and no RAM activity. Drop m_lock: c_ack within 2 cycles.
- CPU read of 0x1FF (preloaded 0x3C) with m_lock rising the cycle after grant:
  - c_ack, then c_rvalid with c_rdata=0x3C.
  - m_rdata unchanged; no further CPU grants.
- rst_n low during RWAIT of a monitor read: no m_rvalid, m_rdata=0, state IDLE.
  - A new request after reset is served with normal latency.

Source files
------------

// File: rtl/ram_arbiter.sv
// Request/acknowledge arbiter sharing one 512x8 RAM between the serial monitor (m_) and the CPU (c_).
// Optional `ARB_ROUND_ROBIN_EN: alternate the winner when both ports are eligible (default: monitor priority).
module ram_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              m_lock,
    output logic              m_ack,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic [ADDR_W-1:0] r_waddr,
    output logic [ADDR_W-1:0] r_raddr,
    output logic [DATA_W-1:0] r_din,
    output logic              r_write_en,
    input  logic [DATA_W-1:0] r_dout
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam logic OWN_M = 1'b0;
    localparam logic OWN_C = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RWAIT = 2'd3
    } state_t;

    state_t            state, state_d;
    logic              owner, owner_d;
    logic              last_winner, last_winner_d;
    logic              m_ack_d, c_ack_d, m_rvalid_d, c_rvalid_d, r_write_en_d;
    logic [DATA_W-1:0] m_rdata_d, c_rdata_d, r_din_d;
    logic [ADDR_W-1:0] r_waddr_d, r_raddr_d;

    logic              m_elig, c_elig, pick_c, win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d       = state;
        owner_d       = owner;
        last_winner_d = last_winner;
        m_ack_d       = 1'b0;
        c_ack_d       = 1'b0;
        m_rvalid_d    = 1'b0;
        c_rvalid_d    = 1'b0;
        r_write_en_d  = 1'b0;
        m_rdata_d     = m_rdata;
        c_rdata_d     = c_rdata;
        r_waddr_d     = r_waddr;
        r_raddr_d     = r_raddr;
        r_din_d       = r_din;

        m_elig    = m_req;
        c_elig    = c_req && !m_lock;
        // CPU wins alone, or on a tie when alternating and the monitor took the last grant
        pick_c    = c_elig && (!m_elig || (RR_EN && (last_winner == OWN_M)));
        win_we    = pick_c ? c_we    : m_we;
        win_addr  = pick_c ? c_addr  : m_addr;
        win_wdata = pick_c ? c_wdata : m_wdata;

        unique case (state)
            IDLE: begin
                if (m_elig || c_elig) begin
                    owner_d       = pick_c ? OWN_C : OWN_M;
                    last_winner_d = pick_c ? OWN_C : OWN_M;
                    m_ack_d       = !pick_c;
                    c_ack_d       = pick_c;
                    if (win_we) begin
                        r_waddr_d    = win_addr;
                        r_din_d      = win_wdata;
                        r_write_en_d = 1'b1;
                        state_d      = WRITE;
                    end else begin
                        r_raddr_d = win_addr;
                        state_d   = READ;
                    end
                end
            end
            WRITE: state_d = IDLE;
            READ:  state_d = RWAIT;
            RWAIT: begin
                state_d = IDLE;
                if (owner == OWN_C) begin
                    c_rdata_d  = r_dout;
                    c_rvalid_d = 1'b1;
                end else begin
                    m_rdata_d  = r_dout;
                    m_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_M;
            last_winner <= OWN_C;
            m_ack       <= 1'b0;
            c_ack       <= 1'b0;
            m_rvalid    <= 1'b0;
            c_rvalid    <= 1'b0;
            m_rdata     <= '0;
            c_rdata     <= '0;
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_din       <= '0;
            r_write_en  <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            last_winner <= last_winner_d;
            m_ack       <= m_ack_d;
            c_ack       <= c_ack_d;
            m_rvalid    <= m_rvalid_d;
            c_rvalid    <= c_rvalid_d;
            m_rdata     <= m_rdata_d;
            c_rdata     <= c_rdata_d;
            r_waddr     <= r_waddr_d;
            r_raddr     <= r_raddr_d;
            r_din       <= r_din_d;
            r_write_en  <= r_write_en_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected acks/rvalids, a negedge monitor pops and compares.
module tb_ram_arbiter;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m_req, m_we, m_lock, c_req, c_we;
    logic [ADDR_W-1:0] m_addr, c_addr;
    logic [DATA_W-1:0] m_wdata, c_wdata;
    logic              m_ack, m_rvalid, c_ack, c_rvalid, r_write_en;
    logic [DATA_W-1:0] m_rdata, c_rdata, r_din, r_dout;
    logic [ADDR_W-1:0] r_waddr, r_raddr;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_lock(m_lock),
        .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .r_waddr(r_waddr), .r_raddr(r_raddr), .r_din(r_din), .r_write_en(r_write_en),
        .r_dout(r_dout)
    );

    // Behavioural RAM with registered read port
    logic [DATA_W-1:0] mem [512];
    always @(posedge clk) begin
        if (r_write_en) mem[r_waddr] <= r_din;
        r_dout <= mem[r_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit              port;
        int              cyc;
        bit              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ack_t;
    typedef struct {
        bit              port;
        int              cyc;
        logic [DATA_W-1:0] data;
    } rv_t;

    ack_t ack_q[$];
    rv_t  rv_q[$];
    ack_t ae;
    rv_t  re;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: exclusivity rules plus in-order scoreboard of acks and rvalids
    always @(negedge clk) begin
        if (mon_en) begin
            check("ack_exclusive", 32'(m_ack & c_ack), 32'd0);
            check("rvalid_exclusive", 32'(m_rvalid & c_rvalid), 32'd0);
            check("write_en_only_with_ack", 32'(r_write_en & ~(m_ack | c_ack)), 32'd0);
            if (m_ack || c_ack) begin
                n_assert++;
                if (ack_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: got m_ack=%0d c_ack=%0d at cycle %0d, expected none",
                             m_ack, c_ack, cyc);
                end else begin
                    ae     = ack_q.pop_front();
                    a_addr = r_write_en ? r_waddr : r_raddr;
                    a_data = r_write_en ? r_din : 8'h00;
                    if (c_ack !== ae.port || cyc != ae.cyc || r_write_en !== ae.we ||
                        a_addr !== ae.addr || a_data !== ae.data) begin
                        n_fail++;
                        $display("FAIL ack: got port=%0d cyc=%0d we=%0d addr=0x%0h data=0x%0h, expected port=%0d cyc=%0d we=%0d addr=0x%0h data=0x%0h",
                                 c_ack, cyc, r_write_en, a_addr, a_data,
                                 ae.port, ae.cyc, ae.we, ae.addr, ae.data);
                    end
                end
            end
            if (m_rvalid || c_rvalid) begin
                n_assert++;
                if (rv_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvalid_unexpected: got m_rvalid=%0d c_rvalid=%0d at cycle %0d, expected none",
                             m_rvalid, c_rvalid, cyc);
                end else begin
                    re = rv_q.pop_front();
                    if (c_rvalid !== re.port || cyc != re.cyc ||
                        (c_rvalid ? c_rdata : m_rdata) !== re.data) begin
                        n_fail++;
                        $display("FAIL rvalid: got port=%0d cyc=%0d data=0x%0h, expected port=%0d cyc=%0d data=0x%0h",
                                 c_rvalid, cyc, c_rvalid ? c_rdata : m_rdata, re.port, re.cyc, re.data);
                    end
                end
            end
        end
    end

    task automatic wait_ack(input bit p, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? c_ack : m_ack) && n < 40);
        n_assert++;
        if (!(p ? c_ack : m_ack)) begin
            n_fail++;
            $display("FAIL %s: got no ack within 40 cycles, expected ack", name);
        end
    endtask

    task automatic wait_rv(input bit p, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? c_rvalid : m_rvalid) && n < 40);
        n_assert++;
        if (!(p ? c_rvalid : m_rvalid)) begin
            n_fail++;
            $display("FAIL %s: got no rvalid within 40 cycles, expected rvalid", name);
        end
    endtask

    // Requester handshake; called just after a posedge, returns just after a posedge
    task automatic access(input bit p, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input string name);
        if (p) begin
            c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
        end else begin
            m_we = we; m_addr = addr; m_wdata = wdata; m_req = 1'b1;
        end
        wait_ack(p, name);
        @(posedge clk); #1;
        if (p) c_req = 1'b0; else m_req = 1'b0;
        if (!we) begin
            wait_rv(p, name);
            @(posedge clk); #1;
        end
    endtask

    // Single uncontended access from idle: ack at issue+1, read data at issue+3
    task automatic op(input bit p, input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rexp, input string name);
        ack_q.push_back('{p, cyc + 1, we, addr, we ? wdata : 8'h00});
        if (!we) rv_q.push_back('{p, cyc + 3, rexp});
        access(p, we, addr, wdata, name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion by time limit, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [ADDR_W-1:0] sv_waddr, sv_raddr;
        rst_n = 1'b0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_lock = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_acks", 32'({m_ack, c_ack, m_rvalid, c_rvalid, r_write_en}), 32'd0);
        check("reset_rdata", 32'({m_rdata, c_rdata}), 32'd0);
        check("reset_ram_side", 32'({r_waddr, r_raddr, r_din}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        op(0, 1, 9'h005, 8'hA5, 8'h00, "m_write_005");
        op(0, 0, 9'h005, 8'h00, 8'hA5, "m_read_005");
        op(0, 1, 9'h1FF, 8'h3C, 8'h00, "m_preload_1ff");
        op(1, 1, 9'h100, 8'h5A, 8'h00, "c_write_100");

        // Simultaneous writes after a CPU grant: monitor first in both modes
        k = cyc;
        ack_q.push_back('{0, k + 1, 1, 9'h010, 8'h11});
        ack_q.push_back('{1, k + 3, 1, 9'h011, 8'h22});
        fork
            access(0, 1, 9'h010, 8'h11, "pair1_m");
            access(1, 1, 9'h011, 8'h22, "pair1_c");
        join
        op(0, 0, 9'h010, 8'h00, 8'h11, "m_read_010");

        // Simultaneous writes after a monitor grant: alternation hands the CPU the tie
        k = cyc;
`ifdef ARB_ROUND_ROBIN_EN
        ack_q.push_back('{1, k + 1, 1, 9'h013, 8'h44});
        ack_q.push_back('{0, k + 3, 1, 9'h012, 8'h33});
`else
        ack_q.push_back('{0, k + 1, 1, 9'h012, 8'h33});
        ack_q.push_back('{1, k + 3, 1, 9'h013, 8'h44});
`endif
        fork
            access(0, 1, 9'h012, 8'h33, "pair2_m");
            access(1, 1, 9'h013, 8'h44, "pair2_c");
        join

        op(1, 0, 9'h011, 8'h00, 8'h22, "c_read_011");
        check("m_rdata_retained", 32'(m_rdata), 32'h11);
        op(1, 0, 9'h013, 8'h00, 8'h44, "c_read_013");
        op(0, 0, 9'h012, 8'h00, 8'h33, "m_read_012");

        // Lock blocks a held CPU request completely
        sv_waddr = r_waddr;
        sv_raddr = r_raddr;
        m_lock = 1'b1;
        c_we = 1'b1; c_addr = 9'h020; c_wdata = 8'h77; c_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("lock_no_activity", 32'({c_ack, r_write_en}), 32'd0);
        end
        check("lock_addr_stable", 32'({sv_waddr, sv_raddr}), 32'({r_waddr, r_raddr}));
        @(posedge clk); #1;
        m_lock = 1'b0;
        ack_q.push_back('{1, cyc + 1, 1, 9'h020, 8'h77});
        wait_ack(1, "unlock_c_ack");
        @(posedge clk); #1;
        c_req = 1'b0;
        op(1, 0, 9'h020, 8'h00, 8'h77, "c_read_020");

        // Lock rising just after a CPU read grant lets that read finish
        k = cyc;
        ack_q.push_back('{1, k + 1, 0, 9'h1FF, 8'h00});
        rv_q.push_back('{1, k + 3, 8'h3C});
        c_we = 1'b0; c_addr = 9'h1FF; c_req = 1'b1;
        @(posedge clk); #1;
        m_lock = 1'b1;
        wait_ack(1, "lockrise_c_ack");
        @(posedge clk); #1;
        c_req = 1'b0;
        wait_rv(1, "lockrise_c_rvalid");
        @(posedge clk); #1;
        c_we = 1'b1; c_addr = 9'h030; c_wdata = 8'h99; c_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("lockrise_no_grant", 32'(c_ack), 32'd0);
        end
        check("lockrise_m_rdata", 32'(m_rdata), 32'h33);
        @(posedge clk); #1;
        c_req = 1'b0;
        @(posedge clk); #1;
        m_lock = 1'b0;

        // Reset lands in RWAIT of a monitor read: read is abandoned
        k = cyc;
        ack_q.push_back('{0, k + 1, 0, 9'h005, 8'h00});
        m_we = 1'b0; m_addr = 9'h005; m_req = 1'b1;
        wait_ack(0, "rst_m_ack");
        @(posedge clk); #1;
        m_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_rwait_rvalid", 32'(m_rvalid), 32'd0);
        check("rst_rwait_rdata", 32'(m_rdata), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_rdata", 32'(m_rdata), 32'd0);
        op(0, 0, 9'h005, 8'h00, 8'hA5, "post_rst_m_read");

        repeat (3) @(posedge clk);
        #1;
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("rvalid_queue_drained", 32'(rv_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
